// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// N-input arbitrated multiplexer with a single registered output stage.
// Each cycle one valid input channel is granted. The choice is either
// round-robin, searching upward from a rotating pointer, or fixed priority
// where the lowest index wins. The granted word and its channel index are
// captured into the output register.
//
// Parameters:
//   N  - number of input channels (2..16)
//   W  - data width per channel
//   RR - 1 = round-robin, 0 = fixed priority (lowest index wins)
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - synchronous active-high reset
//   in_valid  - [N]   per-channel data valid
//   in_ready  - [N]   per-channel accept strobe (one-hot or zero)
//   in_data   - [N*W] channel i occupies bits [i*W+W-1 : i*W]
//   out_valid - output register holds a word
//   out_ready - downstream accepts the word
//   out_data  - [W]   registered selected word
//   out_chan  - [CW]  registered source channel index, CW = clog2(N)
module rr_mux_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RR = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_chan
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] ptr;
  logic [N-1:0]  grant;
  logic [CW-1:0] grant_idx;
  logic          found;
  logic          accept;

  // The output register can take a new word when it is empty or is being
  // drained in this same cycle, which allows one transfer per cycle.
  assign accept = !out_valid || out_ready;

  // Grant search. In round-robin mode the scan starts at ptr and wraps;
  // in fixed-priority mode it always starts at channel 0. The first valid
  // channel found wins, which keeps the grant one-hot.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = k + ((RR != 0) ? int'(ptr) : 0);
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
      end
    end
  end

  // in_ready is masked during reset so no upstream handshake completes
  // in a cycle whose state update will be discarded anyway.
  assign in_ready = (accept && !rst) ? grant : '0;

  // Output register and pointer. A grant with accept is exactly a transfer,
  // since in_ready mirrors the grant whenever accept is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (accept) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant_idx)*W +: W];
        out_chan  <= grant_idx;
        if (RR != 0) begin
          if (grant_idx == CW'(N-1))
            ptr <= '0;
          else
            ptr <= grant_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
